bram_mac_engine: RTL and testbench

- Parametrised successor to the fixed A×B single-product datapath.
- Sequences reads of N operand pairs from two external BRAM ports (A and B) under its own FSM.
- Multiplies each pair through a registered multiplier stage and accumulates a dot product.
- Streams each element product and the final sum, with done/valid handshakes, for downstream slicer/display logic.

---
 rtl/bram_mac_engine.sv | 123 ++++++++++++
 tb/tb_bram_mac_engine.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_mac_engine.sv
// Dot-product engine: reads N operand pairs from two BRAM ports, multiplies each pair, and accumulates the sum.
// Optional build macro BRAM_MAC_ACC_SAT_EN makes the accumulator saturate instead of wrapping.
module bram_mac_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int ACC_W  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W:0]       len,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     dout_A,
  input  logic [DATA_W-1:0]     dout_B,
  output logic [2*DATA_W-1:0]   prod_out,
  output logic                  prod_valid,
  output logic [ACC_W-1:0]      result,
  output logic                  result_valid,
  output logic                  done,
  output logic                  busy,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t              state;
  logic [ADDR_W:0]     len_p0;
  logic                vld_p1;
  logic [ACC_W-1:0]    acc_p2;
  logic [ACC_W:0]      sum_p2;

  // Returns {carry, sum}; in saturating builds a carry pins the sum at the maximum.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [2*DATA_W-1:0] p);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W+1-2*DATA_W){1'b0}}, p};
`ifdef BRAM_MAC_ACC_SAT_EN
    if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
`endif
    return s;
  endfunction

  assign sum_p2 = acc_add(acc_p2, prod_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len_p0       <= '0;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      vld_p1       <= 1'b0;
      prod_out     <= '0;
      prod_valid   <= 1'b0;
      acc_p2       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      done <= 1'b0;

      // Stage 1: BRAM data returns one cycle after the read is issued
      vld_p1 <= mem_en;

      // Stage 2: full-width unsigned product
      prod_valid <= vld_p1;
      if (vld_p1)
        prod_out <= {{DATA_W{1'b0}}, dout_A} * {{DATA_W{1'b0}}, dout_B};

      // Stage 3: accumulate; overflow stays set until the next accepted start
      if (prod_valid) begin
        acc_p2   <= sum_p2[ACC_W-1:0];
        overflow <= overflow | sum_p2[ACC_W];
      end

      case (state)
        IDLE: begin
          if (start) begin
            acc_p2       <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b1;
            if (len != '0) begin
              len_p0   <= (len > DEPTH_L) ? DEPTH_L : len;
              mem_en   <= 1'b1;
              mem_addr <= '0;
              state    <= READ;
            end else begin
              state <= DONE;
            end
          end
        end
        READ: begin
          if ({1'b0, mem_addr} == len_p0 - 1'b1) begin
            mem_en <= 1'b0;
            state  <= DRAIN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        DRAIN: begin
          // The last product is accumulated on the same edge that leaves DRAIN.
          if (!mem_en && !vld_p1)
            state <= DONE;
        end
        DONE: begin
          result       <= acc_p2;
          done         <= 1'b1;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_mac_engine.sv
// Bench for bram_mac_engine: BRAM models, per-scenario tasks, and a product/result scoreboard.
module tb_bram_mac_engine;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int ACC_W  = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [ADDR_W:0]      len = '0;
  logic                 mem_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    dout_A = '0;
  logic [DATA_W-1:0]    dout_B = '0;
  logic [2*DATA_W-1:0]  prod_out;
  logic                 prod_valid;
  logic [ACC_W-1:0]     result;
  logic                 result_valid;
  logic                 done;
  logic                 busy;
  logic                 overflow;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  logic [2*DATA_W-1:0] exp_prod_q[$];
  logic [ADDR_W-1:0]   rd_addr_q[$];
  int                  rd_cyc_q[$];
  logic [2*DATA_W-1:0] pr_q[$];
  int                  pr_cyc_q[$];
  int                  obs_done_cyc;
  int                  obs_dones;
  logic                rv_c1, ovf_c1, busy_c1;

  bram_mac_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .mem_en(mem_en), .mem_addr(mem_addr), .dout_A(dout_A), .dout_B(dout_B),
    .prod_out(prod_out), .prod_valid(prod_valid), .result(result),
    .result_valid(result_valid), .done(done), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      dout_A <= mem_a[mem_addr];
      dout_B <= mem_b[mem_addr];
    end
  end

  task automatic load_basic();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = DATA_W'(i + 1);
      mem_b[i] = DATA_W'(i + 5);
    end
  endtask

  // Starts an operation at edge 0 and captures what the DUT does on cycles 1..budget.
  task automatic run_op(input int n, input int p1, input int p2, input int budget);
    rd_addr_q.delete(); rd_cyc_q.delete(); pr_q.delete(); pr_cyc_q.delete();
    obs_done_cyc = -1;
    obs_dones = 0;
    @(negedge clk);
    start = 1'b1;
    len = (ADDR_W+1)'(n);
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (c == 1) begin
        rv_c1 = result_valid; ovf_c1 = overflow; busy_c1 = busy;
      end
      if (mem_en) begin rd_addr_q.push_back(mem_addr); rd_cyc_q.push_back(c); end
      if (prod_valid) begin pr_q.push_back(prod_out); pr_cyc_q.push_back(c); end
      if (done) begin
        obs_dones++;
        if (obs_done_cyc < 0) obs_done_cyc = c;
      end
      if (c == p1 || c == p2) begin
        start = 1'b1;
        len = 1;
      end else begin
        start = 1'b0;
        len = (ADDR_W+1)'(n);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, mem_en, prod_valid, done, result_valid, overflow} !== 6'b0 || result !== '0) begin
      failures++;
      $display("FAIL reset_state: got flags=%b result=%0h expected 0", {busy, mem_en, prod_valid, done, result_valid, overflow}, result);
    end
    @(negedge clk); rst = 1'b0;
    load_basic();
    exp_prod_q.push_back(64'd5);
    run_op(1, 0, 0, 8);
    checks++;
    if (result !== 64'd5 || obs_done_cyc != 5) begin
      failures++;
      $display("FAIL pre_abort_run: got result=%0h done_cyc=%0d expected 5 / 5", result, obs_done_cyc);
    end
    void'(exp_prod_q.pop_front());
    @(negedge clk); start = 1'b1; len = 8;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || prod_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_run_active: got busy=%b prod_valid=%b expected 1/1", busy, prod_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, mem_en, prod_valid, done, result_valid, overflow} !== 6'b0 || result !== '0) begin
      failures++;
      $display("FAIL async_reset: got flags=%b result=%0h expected 0", {busy, mem_en, prod_valid, done, result_valid, overflow}, result);
    end
    @(negedge clk); rst = 1'b0;
    begin
      int saw_done = 0;
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        if (done || busy) saw_done++;
      end
      checks++;
      if (saw_done != 0) begin
        failures++;
        $display("FAIL no_done_after_abort: got %0d active cycles expected 0", saw_done);
      end
    end
    exp_prod_q.push_back(64'd5);
    run_op(1, 0, 0, 8);
    checks++;
    if (pr_q.size() != 1 || pr_q[0] !== exp_prod_q[0] || pr_cyc_q[0] != 3) begin
      failures++;
      $display("FAIL post_reset_prod: got n=%0d expected 1 product 5 at cycle 3", pr_q.size());
    end
    void'(exp_prod_q.pop_front());
    checks++;
    if (result !== 64'd5 || obs_done_cyc != 5 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_run: got result=%0h done_cyc=%0d rv=%b expected 5 / 5 / 1", result, obs_done_cyc, result_valid);
    end
  endtask

  task automatic test_basic();
    load_basic();
    exp_prod_q.push_back(64'd5);  exp_prod_q.push_back(64'd12);
    exp_prod_q.push_back(64'd21); exp_prod_q.push_back(64'd32);
    run_op(4, 0, 0, 12);
    checks++;
    if (rd_addr_q.size() != 4) begin
      failures++;
      $display("FAIL basic_reads: got %0d expected 4", rd_addr_q.size());
    end
    for (int i = 0; i < rd_addr_q.size() && i < 4; i++) begin
      checks++;
      if (rd_addr_q[i] !== ADDR_W'(i) || rd_cyc_q[i] != i + 1) begin
        failures++;
        $display("FAIL basic_addr%0d: got addr=%0d cyc=%0d expected %0d/%0d", i, rd_addr_q[i], rd_cyc_q[i], i, i + 1);
      end
    end
    checks++;
    if (pr_q.size() != 4) begin
      failures++;
      $display("FAIL basic_prod_count: got %0d expected 4", pr_q.size());
    end
    for (int i = 0; i < pr_q.size() && exp_prod_q.size() > 0; i++) begin
      logic [2*DATA_W-1:0] e;
      e = exp_prod_q.pop_front();
      checks++;
      if (pr_q[i] !== e || pr_cyc_q[i] != i + 3) begin
        failures++;
        $display("FAIL basic_prod%0d: got %0d at cyc %0d expected %0d at cyc %0d", i, pr_q[i], pr_cyc_q[i], e, i + 3);
      end
    end
    exp_prod_q.delete();
    checks++;
    if (obs_done_cyc != 8 || obs_dones != 1) begin
      failures++;
      $display("FAIL basic_done: got cyc=%0d count=%0d expected 8/1", obs_done_cyc, obs_dones);
    end
    checks++;
    if (result !== 64'd70 || overflow !== 1'b0 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_result: got %0d ovf=%b rv=%b expected 70/0/1", result, overflow, result_valid);
    end
  endtask

  task automatic test_len_zero();
    run_op(0, 0, 0, 6);
    checks++;
    if (rd_addr_q.size() != 0 || pr_q.size() != 0) begin
      failures++;
      $display("FAIL len0_activity: got reads=%0d prods=%0d expected 0/0", rd_addr_q.size(), pr_q.size());
    end
    checks++;
    if (obs_done_cyc != 2 || obs_dones != 1) begin
      failures++;
      $display("FAIL len0_done: got cyc=%0d count=%0d expected 2/1", obs_done_cyc, obs_dones);
    end
    checks++;
    if (result !== '0 || result_valid !== 1'b1) begin
      failures++;
      $display("FAIL len0_result: got %0h rv=%b expected 0/1", result, result_valid);
    end
  endtask

  task automatic test_clamp();
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 1;
      mem_b[i] = 1;
    end
    run_op(40, 0, 0, 42);
    checks++;
    if (rd_addr_q.size() != 32) begin
      failures++;
      $display("FAIL clamp_reads: got %0d expected 32", rd_addr_q.size());
    end
    for (int i = 0; i < rd_addr_q.size(); i++)
      if (rd_addr_q[i] !== ADDR_W'(i) || rd_cyc_q[i] != i + 1) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clamp_addr_seq: got %0d out-of-order reads expected 0", bad);
    end
    checks++;
    if (obs_done_cyc != 36 || result !== 64'd32 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL clamp_result: got cyc=%0d result=%0d ovf=%b expected 36/32/0", obs_done_cyc, result, overflow);
    end
  endtask

  task automatic test_overflow();
    logic [ACC_W-1:0] exp_res;
`ifdef BRAM_MAC_ACC_SAT_EN
    exp_res = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    exp_res = 64'hFFFF_FFFC_0000_0002;
`endif
    mem_a[0] = 32'hFFFF_FFFF; mem_a[1] = 32'hFFFF_FFFF;
    mem_b[0] = 32'hFFFF_FFFF; mem_b[1] = 32'hFFFF_FFFF;
    exp_prod_q.push_back(64'hFFFF_FFFE_0000_0001);
    exp_prod_q.push_back(64'hFFFF_FFFE_0000_0001);
    run_op(2, 0, 0, 8);
    for (int i = 0; i < pr_q.size() && exp_prod_q.size() > 0; i++) begin
      logic [2*DATA_W-1:0] e;
      e = exp_prod_q.pop_front();
      checks++;
      if (pr_q[i] !== e) begin
        failures++;
        $display("FAIL ovf_prod%0d: got %0h expected %0h", i, pr_q[i], e);
      end
    end
    checks++;
    if (pr_q.size() != 2 || exp_prod_q.size() != 0) begin
      failures++;
      $display("FAIL ovf_prod_count: got %0d expected 2", pr_q.size());
    end
    exp_prod_q.delete();
    checks++;
    if (result !== exp_res || overflow !== 1'b1 || obs_done_cyc != 6) begin
      failures++;
      $display("FAIL ovf_result: got %0h ovf=%b cyc=%0d expected %0h/1/6", result, overflow, obs_done_cyc, exp_res);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (overflow !== 1'b1 || result_valid !== 1'b1 || result !== exp_res) begin
      failures++;
      $display("FAIL ovf_sticky: got ovf=%b rv=%b result=%0h expected 1/1/%0h", overflow, result_valid, result, exp_res);
    end
  endtask

  task automatic test_back_to_back();
    load_basic();
    run_op(4, 2, 5, 14);
    checks++;
    if (ovf_c1 !== 1'b0 || rv_c1 !== 1'b0 || busy_c1 !== 1'b1) begin
      failures++;
      $display("FAIL start_clears: got ovf=%b rv=%b busy=%b expected 0/0/1", ovf_c1, rv_c1, busy_c1);
    end
    checks++;
    if (obs_dones != 1 || obs_done_cyc != 8 || rd_addr_q.size() != 4) begin
      failures++;
      $display("FAIL ignored_start_done: got count=%0d cyc=%0d reads=%0d expected 1/8/4", obs_dones, obs_done_cyc, rd_addr_q.size());
    end
    checks++;
    if (result !== 64'd70 || overflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start_result: got %0d ovf=%b busy=%b expected 70/0/0", result, overflow, busy);
    end
  endtask

  initial begin
    load_basic();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_len_zero();
    test_clamp();
    test_overflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
